// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle RV32 control FSM (fetch/decode/exec/mem/wb); define CTRL_PERF_CNT_EN for the retired-instruction counter
module cpu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ir_we,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] retired
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7;
  localparam logic [2:0] OP_ADD = 3'b010, OP_SUB = 3'b110;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [2:0] state_q, state_d;
  logic [1:0] err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0] f3, alu_op;
  logic is_r, is_i, is_lw, is_sw, is_beq, is_jal, alu_ok, legal, rd_nz, waiting, tout;
  logic unused_ins;
  assign f3 = ins[14:12];
  assign is_r = ins[6:0] == 7'b0110011;
  assign is_i = ins[6:0] == 7'b0010011;
  assign is_lw = ins[6:0] == 7'b0000011;
  assign is_sw = ins[6:0] == 7'b0100011;
  assign is_beq = ins[6:0] == 7'b1100011;
  assign is_jal = ins[6:0] == 7'b1101111;
  assign rd_nz = ins[11:7] != 5'd0;
  assign alu_ok = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010;
  assign alu_op = f3 == 3'b111 ? 3'b000 : f3 == 3'b110 ? 3'b001 : f3 == 3'b010 ? 3'b111 :
                  (is_r && ins[30]) ? OP_SUB : OP_ADD;
  assign legal = is_lw | is_sw | is_beq | is_jal | ((is_r | is_i) & alu_ok);
  assign waiting = (state_q == FETCH || state_q == MEM) && !mem_ready;
  // ready in the limit cycle wins because tout requires !mem_ready
  assign tout = waiting && tcnt_q == TW'(MEM_TIMEOUT - 1);
  assign unused_ins = ^{ins[31], ins[29:15]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      err_q <= 2'b00;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      tcnt_q <= tcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : tout ? HALT : FETCH;
      DECODE: state_d = legal ? EXEC : HALT;
      EXEC:   state_d = (is_r | is_i) ? WB : (is_lw | is_sw) ? MEM : FETCH;
      MEM:    state_d = mem_ready ? (is_lw ? WB : FETCH) : tout ? HALT : MEM;
      WB:     state_d = FETCH;
      default: state_d = HALT;
    endcase
    if (state_q == DECODE && !legal) err_d = 2'b01;
    if (tout) err_d = 2'b10;
    tcnt_d = state_d != state_q ? '0 : tcnt_q + TW'(waiting);
  end
  always_comb begin
    pc_we = 1'b0;
    pc_sel = 2'b00;
    ir_we = 1'b0;
    RegWrite = 1'b0;
    ALUSrc = 1'b0;
    op = 3'b000;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    wb_sel = 2'b00;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ir_we = mem_ready;
        end
        EXEC: begin
          ALUSrc = is_i | is_lw | is_sw;
          op = (is_r | is_i) ? alu_op : is_beq ? OP_SUB : is_jal ? 3'b000 : OP_ADD;
          RegWrite = is_jal & rd_nz;
          wb_sel = is_jal ? 2'b10 : 2'b00;
          pc_we = is_beq | is_jal;
          pc_sel = is_jal ? 2'b10 : (is_beq && zero) ? 2'b01 : 2'b00;
        end
        MEM: begin
          ALUSrc = 1'b1;
          op = OP_ADD;
          MemRead = is_lw;
          MemWrite = is_sw;
          pc_we = is_sw & mem_ready;
        end
        WB: begin
          ALUSrc = !is_r;
          op = is_lw ? OP_ADD : alu_op;
          RegWrite = rd_nz;
          wb_sel = is_lw ? 2'b01 : 2'b00;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign state = state_q;
  assign halted = state_q == HALT;
  assign err = err_q;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] ret_q;
  always_ff @(posedge clk) begin
    if (reset) ret_q <= '0;
    else ret_q <= ret_q + CNT_W'(pc_we);
  end
  assign retired = ret_q;
`else
  assign retired = '0;
`endif
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed bench for cpu_seq_ctrl with an instruction-level reference model
module tb_cpu_seq_ctrl;
  localparam logic [31:0] ADD = 32'h002081B3, SUB = 32'h402081B3, LW = 32'h00802283, SW = 32'h0020A223;
  localparam logic [31:0] BEQ = 32'h00000463, JAL1 = 32'h010000EF, JAL0 = 32'h0100006F;
  localparam logic [31:0] SLLI = 32'h00109093, BAD = 32'h0000007F;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct packed {
    logic mr, mw, irwe, rw, asrc;
    logic [2:0] op;
    logic pcwe;
    logic [1:0] pcsel, wbsel;
  } ctl_t;
  logic clk = 0, reset = 1, zero = 0, mem_ready = 0;
  logic [31:0] ins = 0;
  logic pc_we, ir_we, RegWrite, ALUSrc, MemRead, MemWrite, halted;
  logic [1:0] pc_sel, wb_sel, err;
  logic [2:0] op, state;
  logic [31:0] retired;
  logic n_rst = 1, n_zero = 0, n_rdy = 0;
  logic [31:0] n_ins = 0;
  int n_tests = 0, n_fail = 0, bad;
  bit mon_on = 0;
  int m_st = 0, m_wt = 0, m_ret = 0, cls, ao;
  logic [1:0] m_err = 0;
  ctl_t e, act;

  cpu_seq_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .op(op), .MemRead(MemRead), .MemWrite(MemWrite), .wb_sel(wb_sel), .state(state),
    .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;
  assign act = '{mr: MemRead, mw: MemWrite, irwe: ir_we, rw: RegWrite, asrc: ALUSrc, op: op,
                 pcwe: pc_we, pcsel: pc_sel, wbsel: wb_sel};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  function automatic int klass(input logic [31:0] i);
    case (i[6:0])
      7'h33: return 0;
      7'h13: return 1;
      7'h03: return 2;
      7'h23: return 3;
      7'h63: return 4;
      7'h6F: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int aluop(input logic [31:0] i);
    case (i[14:12])
      3'd0: return (i[6:0] == 7'h33 && i[30]) ? 6 : 2;
      3'd7: return 0;
      3'd6: return 1;
      3'd2: return 7;
      default: return -1;
    endcase
  endfunction

  // instruction-level model: step index 0..4 / 7, wait count, sticky error, retire count
  initial begin
    wait (mon_on);
    forever begin
      @(negedge clk);
      cls = klass(ins);
      ao = aluop(ins);
      e = '0;
      if (!reset) begin
        case (m_st)
          0: begin e.mr = 1; e.irwe = mem_ready; end
          2: case (cls)
            0: e.op = 3'(ao);
            1: begin e.asrc = 1; e.op = 3'(ao); end
            2, 3: begin e.asrc = 1; e.op = 3'd2; end
            4: begin e.op = 3'd6; e.pcwe = 1; e.pcsel = zero ? 2'd1 : 2'd0; end
            5: begin e.rw = ins[11:7] != 0; e.wbsel = 2'd2; e.pcwe = 1; e.pcsel = 2'd2; end
            default: ;
          endcase
          3: begin
            e.asrc = 1; e.op = 3'd2; e.mr = cls == 2; e.mw = cls == 3;
            e.pcwe = cls == 3 && mem_ready;
          end
          4: begin
            e.rw = ins[11:7] != 0; e.wbsel = cls == 2 ? 2'd1 : 2'd0; e.pcwe = 1;
            e.asrc = cls != 0; e.op = cls == 2 ? 3'd2 : 3'(ao);
          end
          default: ;
        endcase
      end
      chk("mon_ctrl", 32'(act), 32'(e));
      chk("mon_state", 32'(state), m_st);
      chk("mon_err", 32'(err), 32'(m_err));
      chk("mon_halted", 32'(halted), 32'(m_st == 7));
      chk("mon_retired", retired, PERF ? m_ret : 0);
      if (reset) begin
        m_st = 0; m_wt = 0; m_err = 0; m_ret = 0;
      end else begin
        m_ret += int'(e.pcwe);
        case (m_st)
          0, 3: if (mem_ready) begin
            m_st = m_st == 0 ? 1 : (cls == 2 ? 4 : 0);
            m_wt = 0;
          end else begin
            m_wt++;
            if (m_wt == 15) begin m_st = 7; m_err = 2; end
          end
          1: if (cls >= 0 && (cls > 1 || ao >= 0)) m_st = 2;
             else begin m_st = 7; m_err = 1; end
          2: begin m_st = cls < 2 ? 4 : cls < 4 ? 3 : 0; m_wt = 0; end
          4: begin m_st = 0; m_wt = 0; end
          default: ;
        endcase
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
    reset = n_rst; ins = n_ins; zero = n_zero; mem_ready = n_rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1;
    go();
    n_rst = 0;
  endtask

  initial begin
    go();
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", 32'(act), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_retired", retired, 0);
    mon_on = 1;
    do_reset();
    n_ins = ADD; n_rdy = 1;
    go(); chk("add_fetch", 32'(state), 0); chk("add_irwe", 32'(ir_we), 1);
    go(); chk("add_decode", 32'(state), 1);
    go(); chk("add_exec", 32'(state), 2); chk("add_exec_op", 32'(op), 3'b010);
    go(); chk("add_wb", 32'(state), 4); chk("add_wb_rw", 32'(RegWrite), 1);
    chk("add_wb_op", 32'(op), 3'b010); chk("add_wb_pcwe", 32'(pc_we), 1);
    n_ins = SUB;
    go(); go(); go(); chk("sub_exec_op", 32'(op), 3'b110);
    go();
    n_ins = LW;
    go(); go(); go();
    n_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      go(); chk("lw_mem_wait", 32'({state, MemRead}), {3'd3, 1'b1});
    end
    n_rdy = 1;
    go(); chk("lw_mem_last", 32'({state, MemRead}), {3'd3, 1'b1});
    go(); chk("lw_wb", 32'({state, wb_sel, RegWrite}), {3'd4, 2'b01, 1'b1});
    n_ins = BEQ; n_zero = 1;
    go(); go(); go(); chk("beq_taken", 32'({pc_sel, pc_we}), {2'b01, 1'b1});
    n_zero = 0;
    go(); chk("beq_next_fetch", 32'(state), 0);
    go(); go(); chk("beq_not_taken", 32'({pc_sel, pc_we}), {2'b00, 1'b1});
    n_ins = JAL1;
    go(); go(); go(); chk("jal_x1", 32'({RegWrite, wb_sel, pc_sel}), {1'b1, 2'b10, 2'b10});
    n_ins = JAL0;
    go(); go(); go(); chk("jal_x0_rw", 32'(RegWrite), 0);
    n_ins = SLLI;
    go(); go(); go(); chk("ifunct3_halt", 32'({state, err}), {3'd7, 2'b01});
    do_reset();
    n_ins = BAD;
    go(); go(); go(); chk("bad_op_halt", 32'({state, err, halted}), {3'd7, 2'b01, 1'b1});
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      n_rdy = 1'(i);
      go();
      if (act != 0 || !halted || err != 2'b01) bad++;
    end
    chk("halt_quiet_20", bad, 0);
    n_ins = ADD; n_rdy = 0;
    do_reset();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      go();
      if (state != 0) bad++;
    end
    chk("fetch_wait15", bad, 0);
    go(); chk("fetch_timeout", 32'({state, err}), {3'd7, 2'b10});
    do_reset();
    for (int i = 0; i < 14; i++) go();
    n_rdy = 1;
    go(); chk("ready_at_limit", 32'({state, ir_we}), {3'd0, 1'b1});
    n_rdy = 0;
    go(); chk("limit_decode", 32'({state, err}), {3'd1, 2'b00});
    do_reset();
    n_rdy = 1;
    for (int i = 0; i < 12; i++) go();
    n_ins = SW;
    for (int i = 0; i < 4; i++) go();
    go(); chk("retired_4", retired, PERF ? 4 : 0);
    do_reset();
    go(); go(); go();
    n_rdy = 0;
    go(); chk("sw_mem", 32'({state, MemWrite}), {3'd3, 1'b1});
    n_rst = 1; n_rdy = 1;
    go(); chk("sw_reset_mid", 32'({state, MemWrite, pc_we}), {3'd3, 1'b0, 1'b0});
    n_rst = 0;
    go(); chk("sw_abort_fetch", 32'(state), 0); chk("sw_abort_ret", retired, 0);
    go();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
